text_write_ctrl: RTL and testbench
==================================

Name: text_write_ctrl

Overview:
- Sequences all writes into the ROWS x COLS character RAM that the VGA text renderer reads.
- Accepts received UART bytes over a valid/ready handshake and owns the text cursor.
- Interprets printable characters, CR/LF, backspace and form-feed, and runs a full-screen clear sweep.
- Is the sole driver of the RAM write port; the renderer keeps the read port.

Parameters:
COLS, 32, characters per row (power of 2, >=2)
ROWS, 4, rows on screen (power of 2, >=2)
BLANK, 8'h20, byte written by clear and backspace
CLEAR_ON_RESET, 1, run a clear sweep automatically after reset deasserts

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
in_data  in  8  received byte
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts in_data this cycle
clear_req  in  1  single-cycle clear request
we  out  1  RAM write enable, one-cycle pulse
wrow  out  clog2(ROWS)  RAM write row
wcol  out  clog2(COLS)  RAM write column
wdata  out  8  RAM write data
cur_row  out  clog2(ROWS)  cursor row (for 7-seg debug)
cur_col  out  clog2(COLS)  cursor column
busy  out  1  clear sweep in progress

Behaviour:
- Reset (reset=0, async): state=IDLE, cursor=(0,0), we=0, wrow/wcol/wdata=0, busy=0, cr_seen=0. On the first clock after release, enter CLEAR if CLEAR_ON_RESET=1.
- States: IDLE, CLEAR.
- in_ready = (state==IDLE) && !clear_req. This output is combinational; all other outputs are registered.
- Acceptance: in_valid && in_ready at edge N updates the cursor at edge N. Any resulting write has we=1 during cycle N+1 with wrow/wcol/wdata registered. One byte per cycle; back-to-back sustained.
- Printable 0x20..0x7E: write byte at the cursor, then advance the cursor.
  - col = col+1.
  - At col==COLS-1: col=0, row=(row+1) mod ROWS.
  - Clear cr_seen.
- 0x0D (CR): col=0, row=(row+1) mod ROWS, no write, set cr_seen.
- 0x0A (LF):
  - If cr_seen: no action; this collapses CRLF into one newline.
  - Otherwise: same action as CR.
  - Clear cr_seen in both cases.
- 0x08 (BS): move the cursor back and write BLANK at the new position. No wrap above the top; clear cr_seen.
  - col>0: col-1.
  - col==0 and row>0: row-1, col=COLS-1.
  - At (0,0): no write, no move.
- 0x0C (FF): accepted, then enter CLEAR.
- Any other byte: accepted and dropped; clear cr_seen.
- clear_req in IDLE: enter CLEAR next edge. If it coincides with in_valid, the byte is not accepted (in_ready=0) and must be held by the sender.
- clear_req while in CLEAR: ignored.
- CLEAR sweep:
  - busy=1.
  - Writes BLANK to every cell, one per cycle, row-major from (0,0) to (ROWS-1,COLS-1).
  - ROWS*COLS consecutive we pulses.
  - After the last write: cursor=(0,0), cr_seen=0, busy=0, return to IDLE. in_ready rises the cycle after the last we.
- Reset mid-sweep aborts immediately; partially cleared RAM is acceptable.
- All counters wrap modulo their width; no saturation.

Decomposition:
- Shared package text_pkg holds the byte constants: CH_CR=8'h0D, CH_LF=8'h0A, CH_BS=8'h08, CH_FF=8'h0C, CH_SP=8'h20, CH_DEL_MAX=8'h7E.
- The package also holds the state encoding.
- One natural sub-module, text_cursor: holds row/col, with advance/newline/back/home commands and wrap logic. The FSM and write-port registers stay in text_write_ctrl.

Test Plan:
1. Reset low then high, CLEAR_ON_RESET=1 -> busy=1; exactly 128 we pulses with wdata=8'h20, addresses (0,0)..(3,31) in order; then in_ready=1 and cursor=(0,0).
2. Send "AB" back-to-back -> we at (0,0)=8'h41 then (0,1)=8'h42 on consecutive cycles; cursor=(0,2).
3. Cursor at (3,31), send 8'h5A -> write (3,31)=8'h5A; cursor wraps to (0,0).
4. Send 0x0D,0x0A from (1,5) -> cursor=(2,0), no we. Send a lone 0x0A -> cursor=(3,0).
5. Cursor (2,0), send 0x08 -> write (1,31)=8'h20, cursor=(1,31). At (0,0), 0x08 -> no we, cursor unchanged.
6. clear_req coincident with in_valid=1, in_data=8'h41 -> in_ready=0 and no write of 0x41. Assert reset=0 at sweep cell 40 -> we=0, busy=0 immediately. After release with CLEAR_ON_RESET=0 -> IDLE, cursor=(0,0).

Source files
------------

// File: rtl/text_pkg.sv
// text_pkg: byte constants, FSM and cursor-command encodings shared by the text write path.
package text_pkg;
  localparam logic [7:0] CH_CR      = 8'h0D;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_BS      = 8'h08;
  localparam logic [7:0] CH_FF      = 8'h0C;
  localparam logic [7:0] CH_SP      = 8'h20;
  localparam logic [7:0] CH_DEL_MAX = 8'h7E;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
  typedef enum logic [2:0] {CMD_NONE, CMD_ADV, CMD_NL, CMD_BACK, CMD_HOME} cur_cmd_e;
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_SP) && (b <= CH_DEL_MAX);
  endfunction
endpackage

// File: rtl/text_cursor.sv
// text_cursor: text cursor position with advance/newline/back/home commands and wrap logic.
module text_cursor
  import text_pkg::*;
#(
  parameter int COLS = 32,
  parameter int ROWS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  cur_cmd_e                cmd,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(COLS)-1:0] col,
  output logic [$clog2(ROWS)-1:0] prev_row,
  output logic [$clog2(COLS)-1:0] prev_col,
  output logic                    at_origin
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  // Position one cell back in row-major order; only meaningful away from the origin.
  assign prev_col  = col_q - CW'(1);
  assign prev_row  = (col_q == '0) ? row_q - RW'(1) : row_q;
  assign at_origin = (row_q == '0) && (col_q == '0);
  assign row = row_q;
  assign col = col_q;
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    case (cmd)
      CMD_ADV: begin
        col_d = col_q + CW'(1);
        row_d = (col_q == COL_MAX) ? row_q + RW'(1) : row_q;
      end
      CMD_NL: begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end
      CMD_BACK: begin
        row_d = at_origin ? row_q : prev_row;
        col_d = at_origin ? col_q : prev_col;
      end
      CMD_HOME: begin
        row_d = '0;
        col_d = '0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
endmodule

// File: rtl/text_write_ctrl.sv
// text_write_ctrl: sole writer of the character RAM; interprets UART bytes and runs clear sweeps.
module text_write_ctrl
  import text_pkg::*;
#(
  parameter int         COLS           = 32,
  parameter int         ROWS           = 4,
  parameter logic [7:0] BLANK          = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    clear_req,
  output logic                    we,
  output logic [$clog2(ROWS)-1:0] wrow,
  output logic [$clog2(COLS)-1:0] wcol,
  output logic [7:0]              wdata,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic                    busy
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int NW = RW + CW;
  localparam logic [NW:0] CLR_ONE = {{NW{1'b0}}, 1'b1};
  state_e        state_q, state_d;
  logic          init_q, init_d;
  logic          cr_seen_q, cr_seen_d;
  logic [NW:0]   clr_q, clr_d;
  logic          we_q, we_d;
  logic [RW-1:0] wrow_q, wrow_d;
  logic [CW-1:0] wcol_q, wcol_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          busy_q, busy_d;
  cur_cmd_e      cmd;
  logic [RW-1:0] prow;
  logic [CW-1:0] pcol;
  logic          at_origin;
  logic          accept;
  // The first cycle after reset is reserved for the automatic clear, so no byte is taken then.
  assign in_ready = (state_q == ST_IDLE) && !clear_req && !init_q;
  assign accept   = in_valid && in_ready;
  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd),
    .row       (cur_row),
    .col       (cur_col),
    .prev_row  (prow),
    .prev_col  (pcol),
    .at_origin (at_origin)
  );
  always_comb begin
    state_d   = state_q;
    init_d    = 1'b0;
    cr_seen_d = cr_seen_q;
    clr_d     = clr_q;
    we_d      = 1'b0;
    wrow_d    = wrow_q;
    wcol_d    = wcol_q;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    cmd       = CMD_NONE;
    if (state_q == ST_CLEAR) begin
      // The extra counter bit holds CLEAR one cycle past the last write so in_ready rises after it.
      if (clr_q[NW]) begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        cr_seen_d = 1'b0;
        cmd       = CMD_HOME;
      end else begin
        we_d             = 1'b1;
        {wrow_d, wcol_d} = clr_q[NW-1:0];
        wdata_d          = BLANK;
        clr_d            = clr_q + CLR_ONE;
      end
    end else if (init_q || clear_req) begin
      state_d = ST_CLEAR;
      busy_d  = 1'b1;
      clr_d   = '0;
    end else if (accept) begin
      if (is_printable(in_data)) begin
        we_d      = 1'b1;
        wrow_d    = cur_row;
        wcol_d    = cur_col;
        wdata_d   = in_data;
        cmd       = CMD_ADV;
        cr_seen_d = 1'b0;
      end else if (in_data == CH_CR) begin
        cmd       = CMD_NL;
        cr_seen_d = 1'b1;
      end else if (in_data == CH_LF) begin
        cmd       = cr_seen_q ? CMD_NONE : CMD_NL;
        cr_seen_d = 1'b0;
      end else if (in_data == CH_BS) begin
        we_d      = !at_origin;
        wrow_d    = at_origin ? wrow_q : prow;
        wcol_d    = at_origin ? wcol_q : pcol;
        wdata_d   = at_origin ? wdata_q : BLANK;
        cmd       = CMD_BACK;
        cr_seen_d = 1'b0;
      end else if (in_data == CH_FF) begin
        state_d = ST_CLEAR;
        busy_d  = 1'b1;
        clr_d   = '0;
      end else begin
        cr_seen_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      init_q    <= CLEAR_ON_RESET;
      cr_seen_q <= 1'b0;
      clr_q     <= '0;
      we_q      <= 1'b0;
      wrow_q    <= '0;
      wcol_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      cr_seen_q <= cr_seen_d;
      clr_q     <= clr_d;
      we_q      <= we_d;
      wrow_q    <= wrow_d;
      wcol_q    <= wcol_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
    end
  end
  assign we    = we_q;
  assign wrow  = wrow_q;
  assign wcol  = wcol_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_text_write_ctrl.sv
// tb_text_write_ctrl: directed vector table plus hand sequences for sweeps, wrap, clear_req and reset abort.
module tb_text_write_ctrl;
  typedef struct {
    string      nm;
    logic [7:0] d;
    bit         exp_we;
    int         wr;
    int         wc;
    logic [7:0] wd;
    int         cr;
    int         cc;
  } vec_t;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       clear_req = 1'b0;
  logic       in_ready, we, busy;
  logic [1:0] wrow, cur_row;
  logic [4:0] wcol, cur_col;
  logic [7:0] wdata;
  logic       rst0 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic       valid0 = 1'b0;
  logic       clear0 = 1'b0;
  logic       in_ready0, we0, busy0;
  logic [1:0] wrow0, cur_row0;
  logic [4:0] wcol0, cur_col0;
  logic [7:0] wdata0;
  int checks = 0;
  int failures = 0;
  vec_t tbl[15];
  always #5 clk = ~clk;
  text_write_ctrl #(.COLS(32), .ROWS(4), .BLANK(8'h20), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .clear_req(clear_req), .we(we), .wrow(wrow), .wcol(wcol), .wdata(wdata),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );
  text_write_ctrl #(.COLS(32), .ROWS(4), .BLANK(8'h20), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .in_data(data0), .in_valid(valid0), .in_ready(in_ready0),
    .clear_req(clear0), .we(we0), .wrow(wrow0), .wcol(wcol0), .wdata(wdata0),
    .cur_row(cur_row0), .cur_col(cur_col0), .busy(busy0)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    in_data  = v.d;
    in_valid = 1'b1;
    chk({v.nm, "_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({v.nm, "_we"}, we, v.exp_we);
    if (v.exp_we) begin
      chk({v.nm, "_wrow"}, wrow, v.wr);
      chk({v.nm, "_wcol"}, wcol, v.wc);
      chk({v.nm, "_wdata"}, wdata, v.wd);
    end
    chk({v.nm, "_cur_row"}, cur_row, v.cr);
    chk({v.nm, "_cur_col"}, cur_col, v.cc);
  endtask
  task automatic sweep_check(input bit poke);
    int n = 0;
    int bad = 0;
    int cyc = 0;
    while (n < 128 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      clear_req = poke && (cyc == 5);
      if (we) begin
        if (int'(wrow) != n / 32 || int'(wcol) != n % 32 || wdata != 8'h20 || !busy) bad++;
        if (n == 127 && in_ready) bad++;
        n++;
      end else if (n > 0) bad++;
    end
    clear_req = 1'b0;
    chk("sweep_count", n, 128);
    chk("sweep_order", bad, 0);
    @(posedge clk);
    #1;
    chk("sweep_done_we", we, 0);
    chk("sweep_done_busy", busy, 0);
    chk("sweep_done_ready", in_ready, 1);
    chk("sweep_done_row", cur_row, 0);
    chk("sweep_done_col", cur_col, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    int hit;
    int k;
    int bad41;
    tbl[0]  = '{"A",       8'h41, 1, 0, 0,  8'h41, 0, 1};
    tbl[1]  = '{"B",       8'h42, 1, 0, 1,  8'h42, 0, 2};
    tbl[2]  = '{"cr",      8'h0D, 0, 0, 0,  8'h00, 1, 0};
    tbl[3]  = '{"lf_crlf", 8'h0A, 0, 0, 0,  8'h00, 1, 0};
    tbl[4]  = '{"lf_lone", 8'h0A, 0, 0, 0,  8'h00, 2, 0};
    tbl[5]  = '{"bs_wrap", 8'h08, 1, 1, 31, 8'h20, 1, 31};
    tbl[6]  = '{"x_eol",   8'h78, 1, 1, 31, 8'h78, 2, 0};
    tbl[7]  = '{"ctl01",   8'h01, 0, 0, 0,  8'h00, 2, 0};
    tbl[8]  = '{"cr2",     8'h0D, 0, 0, 0,  8'h00, 3, 0};
    tbl[9]  = '{"del7f",   8'h7F, 0, 0, 0,  8'h00, 3, 0};
    tbl[10] = '{"lf_wrap", 8'h0A, 0, 0, 0,  8'h00, 0, 0};
    tbl[11] = '{"bs_org",  8'h08, 0, 0, 0,  8'h00, 0, 0};
    tbl[12] = '{"tilde",   8'h7E, 1, 0, 0,  8'h7E, 0, 1};
    tbl[13] = '{"ctl1f",   8'h1F, 0, 0, 0,  8'h00, 0, 1};
    tbl[14] = '{"space",   8'h20, 1, 0, 1,  8'h20, 0, 2};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrow", wrow, 0);
    chk("rst_wcol", wcol, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_cur_row", cur_row, 0);
    chk("rst_cur_col", cur_col, 0);
    chk("rst0_we", we0, 0);
    chk("rst0_busy", busy0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("por_busy", busy, 1);
    chk("por_ready", in_ready, 0);
    sweep_check(1'b0);
    for (int i = 0; i < 15; i++) apply(tbl[i]);
    for (int i = 0; i < 3; i++) apply('{"cr_fill", 8'h0D, 0, 0, 0, 8'h00, i + 1, 0});
    for (int i = 0; i < 31; i++) apply('{"fill", 8'h2E, 1, 3, i, 8'h2E, 3, i + 1});
    apply('{"Z_wrap", 8'h5A, 1, 3, 31, 8'h5A, 0, 0});
    apply('{"cr_r1", 8'h0D, 0, 0, 0, 8'h00, 1, 0});
    for (int i = 0; i < 5; i++) apply('{"r1_fill", 8'h2E, 1, 1, i, 8'h2E, 1, i + 1});
    apply('{"crlf_cr", 8'h0D, 0, 0, 0, 8'h00, 2, 0});
    apply('{"crlf_lf", 8'h0A, 0, 0, 0, 8'h00, 2, 0});
    apply('{"lone_lf", 8'h0A, 0, 0, 0, 8'h00, 3, 0});
    apply('{"ff", 8'h0C, 0, 0, 0, 8'h00, 3, 0});
    chk("ff_busy", busy, 1);
    chk("ff_ready", in_ready, 0);
    sweep_check(1'b1);
    clear_req = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h41;
    #1;
    chk("creq_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    in_valid  = 1'b0;
    chk("creq_we", we, 0);
    chk("creq_busy", busy, 1);
    hit = 0;
    k = 0;
    bad41 = 0;
    while (hit == 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (we && wdata == 8'h41) bad41++;
      if (we && wrow == 2'd1 && wcol == 5'd8) hit = 1;
    end
    chk("abort_cell40_seen", hit, 1);
    chk("creq_no_41", bad41, 0);
    reset = 1'b0;
    #1;
    chk("abort_we", we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cur_row", cur_row, 0);
    chk("abort_cur_col", cur_col, 0);
    @(negedge clk);
    reset = 1'b1;
    sweep_check(1'b0);
    apply('{"after_A", 8'h41, 1, 0, 0, 8'h41, 0, 1});
    @(negedge clk);
    rst0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("nocor_busy", busy0, 0);
    chk("nocor_we", we0, 0);
    chk("nocor_ready", in_ready0, 1);
    chk("nocor_cur_row", cur_row0, 0);
    chk("nocor_cur_col", cur_col0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
